// File: rtl/keyed_lane_perm_if.sv
// Valid/ready stream bundle for the keyed lane permutation network.
// The input and output beats share one interface; the block takes the slave view.
interface keyed_lane_perm_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/keyed_lane_perm.sv
// Pipelined keyed butterfly permutation: log2(N) registered swap stages, each
// steered by its slice of a key snapshot that travels with the beat.
module keyed_lane_perm #(
  parameter int N = 4,
  parameter int W = 8,
  parameter logic [(N/2)*$clog2(N)-1:0] KEY_RESET = '1
) (
  input  logic                          clk,
  input  logic                          rst,
  keyed_lane_perm_if.slave              bus,
  input  logic                          key_load,
  input  logic [(N/2)*$clog2(N)-1:0]    key_in,
  input  logic                          roll_en,
  output logic [(N/2)*$clog2(N)-1:0]    key_q
);
  localparam int L  = $clog2(N);
  localparam int NP = N / 2;
  localparam int KW = NP * L;

  logic adv;
  logic accept;
  logic [KW-1:0] key_d;

  logic [N-1:0][W-1:0] stage_in   [L];
  logic [KW-1:0]       stage_key  [L];
  logic [N-1:0][W-1:0] stage_perm [L];

  logic [N-1:0][W-1:0] data_q [L];
  logic [KW-1:0]       snap_q [L-1];
  logic [L-1:0]        vld_q;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;

  genvar gi, gp;
  generate
    for (gi = 0; gi < L; gi++) begin : g_stage
      logic [N-1:0][W-1:0] swapped;

      if (gi == 0) begin : g_first
        assign stage_in[gi]  = bus.in_data;
        assign stage_key[gi] = key_q;
      end else begin : g_rest
        assign stage_in[gi]  = data_q[gi-1];
        assign stage_key[gi] = snap_q[gi-1];
      end

      // Pair p joins lane i (bit gi clear) with lane i + 2^gi, enumerated by increasing i.
      for (gp = 0; gp < NP; gp++) begin : g_pair
        localparam int LO = gp % (1 << gi);
        localparam int LI = (gp >> gi) * (2 << gi) + LO;
        localparam int HI = LI + (1 << gi);
        localparam int KB = gi * NP + gp;

        assign swapped[LI] = stage_key[gi][KB] ? stage_in[gi][HI] : stage_in[gi][LI];
        assign swapped[HI] = stage_key[gi][KB] ? stage_in[gi][LI] : stage_in[gi][HI];
      end

      assign stage_perm[gi] = swapped;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < L; s++) begin
        data_q[s] <= '0;
      end
      for (int s = 0; s < L - 1; s++) begin
        snap_q[s] <= '0;
      end
    end else if (adv) begin
      vld_q <= {vld_q[L-2:0], accept};
      for (int s = 0; s < L; s++) begin
        data_q[s] <= stage_perm[s];
      end
      snap_q[0] <= key_q;
      for (int s = 1; s < L - 1; s++) begin
        snap_q[s] <= snap_q[s-1];
      end
    end
  end

  // Load beats roll; the beat accepted alongside a load still used the old key.
  always_comb begin
    key_d = key_q;
    if (key_load) begin
      key_d = key_in;
    end else if (roll_en && accept) begin
      key_d = {key_q[KW-2:0], key_q[KW-1] ^ key_q[KW-2]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= KEY_RESET;
    end else begin
      key_q <= key_d;
    end
  end

  assign bus.out_valid = vld_q[L-1];
  assign bus.out_data  = data_q[L-1];
endmodule

// File: tb/tb_keyed_lane_perm.sv
// Randomised bench for keyed_lane_perm (N=4, W=8): a lane-array reference model
// predicts each accepted beat's permutation and the key register evolution.
module tb_keyed_lane_perm;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int KW = 4;
  localparam logic [KW-1:0] KEY_RST = 4'hF;
  localparam logic [31:0] LANES = 32'h44332211;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_load = 1'b0;
  logic [KW-1:0] key_in = '0;
  logic roll_en = 1'b0;
  logic [KW-1:0] key_q;

  keyed_lane_perm_if #(.N(N), .W(W)) bus ();

  keyed_lane_perm #(.N(N), .W(W), .KEY_RESET(KEY_RST)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .key_load (key_load),
    .key_in   (key_in),
    .roll_en  (roll_en),
    .key_q    (key_q)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [KW-1:0] model_key = KEY_RST;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  function automatic logic [31:0] permute(input logic [31:0] d, input logic [KW-1:0] k);
    logic [7:0] ln [4];
    logic [7:0] t;
    logic [31:0] r;
    int p;
    for (int i = 0; i < 4; i++) ln[i] = d[i*8 +: 8];
    for (int s = 0; s < 2; s++) begin
      p = 0;
      for (int i = 0; i < 4; i++) begin
        if (((i >> s) & 1) == 0) begin
          if (k[s*2 + p]) begin
            t = ln[i];
            ln[i] = ln[i + (1 << s)];
            ln[i + (1 << s)] = t;
          end
          p++;
        end
      end
    end
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = ln[i];
    return r;
  endfunction

  function automatic logic [KW-1:0] roll(input logic [KW-1:0] k);
    return {k[2:0], k[3] ^ k[2]};
  endfunction

  // One cycle: observe handshakes mid-cycle, update the model, end just after the edge.
  task automatic tick();
    logic acc;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      obs_q.push_back(bus.out_data);
      $display("[TB] out beat %h", bus.out_data);
    end
    if (rst) begin
      while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
      model_key = KEY_RST;
    end else begin
      acc = bus.in_valid && bus.in_ready;
      if (acc) exp_q.push_back(permute(bus.in_data, model_key));
      if (key_load) model_key = key_in;
      else if (roll_en && acc) model_key = roll(model_key);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    tests_run++;
    if (key_q !== KEY_RST) begin
      tests_failed++; $display("FAIL reset_key got %h want %h", key_q, KEY_RST);
    end
    tests_run++;
    if (bus.out_data !== 32'h0) begin
      tests_failed++; $display("FAIL reset_out_data got %h want 0", bus.out_data);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_identity();
    key_load = 1'b1; key_in = 4'h0;
    tick();
    key_load = 1'b0;
    tests_run++;
    if (key_q !== 4'h0) begin
      tests_failed++; $display("FAIL ident_key_load got %h want 0", key_q);
    end
    bus.in_valid = 1'b1; bus.in_data = LANES;
    tick();
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL ident_early_valid got %b want 0", bus.out_valid);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== LANES) begin
      tests_failed++;
      $display("FAIL ident_out got valid=%b data=%h want valid=1 data=%h", bus.out_valid, bus.out_data, LANES);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL ident_valid_width got %b want 0", bus.out_valid);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_single_swaps();
    logic [KW-1:0] keys [3];
    logic [31:0] exps [3];
    keys = '{4'h1, 4'h4, 4'hF};
    exps = '{32'h44331122, 32'h44112233, 32'h11223344};
    for (int t = 0; t < 3; t++) begin
      key_load = 1'b1; key_in = keys[t];
      tick();
      key_load = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = LANES;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exps[t]) begin
        tests_failed++;
        $display("FAIL swap_key%h got valid=%b data=%h want data=%h", keys[t], bus.out_valid, bus.out_data, exps[t]);
      end
      tick();
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_roll();
    logic [31:0] o, e;
    roll_en = 1'b1;
    key_load = 1'b1; key_in = 4'h1;
    tick();
    key_load = 1'b0;
    tests_run++;
    if (key_q !== 4'h1) begin
      tests_failed++; $display("FAIL roll_load got %h want 1", key_q);
    end
    for (int b = 0; b < 5; b++) begin
      bus.in_valid = 1'b1; bus.in_data = $urandom;
      tick();
      tests_run++;
      if (key_q !== model_key) begin
        tests_failed++; $display("FAIL roll_key beat%0d got %h want %h", b, key_q, model_key);
      end
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    roll_en = 1'b0;
    tests_run++;
    if (obs_q.size() != 5 || exp_q.size() != 5) begin
      tests_failed++; $display("FAIL roll_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL roll_data got %h want %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] held, o, e;
    logic [KW-1:0] hk;
    bus.out_ready = 1'b0; roll_en = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.in_valid = 1'b1; bus.in_data = $urandom;
      tick();
    end
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL bp_stall got in_ready=%b out_valid=%b want 0/1", bus.in_ready, bus.out_valid);
    end
    tests_run++;
    if (exp_q.size() != 2) begin
      tests_failed++; $display("FAIL bp_accepted got %0d want 2", exp_q.size());
    end
    held = bus.out_data; hk = key_q;
    for (int c = 0; c < 3; c++) begin
      bus.in_data = $urandom;
      tick();
      tests_run++;
      if (bus.out_data !== held || key_q !== hk) begin
        tests_failed++;
        $display("FAIL bp_hold got data=%h key=%h want data=%h key=%h", bus.out_data, key_q, held, hk);
      end
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    repeat (4) tick();
    roll_en = 1'b0;
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL bp_data got %h want %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_collision();
    roll_en = 1'b0;
    key_load = 1'b1; key_in = 4'h0;
    tick();
    key_in = 4'hF;
    bus.in_valid = 1'b1; bus.in_data = LANES;
    tick();
    key_load = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== LANES) begin
      tests_failed++; $display("FAIL collide_first got %h want %h", bus.out_data, LANES);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11223344) begin
      tests_failed++; $display("FAIL collide_second got %h want 11223344", bus.out_data);
    end
    tick();
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    int stale;
    logic [31:0] o, e;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = $urandom;
    tick();
    bus.in_data = $urandom;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1; key_load = 1'b1; key_in = 4'h0;
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0 || key_q !== KEY_RST) begin
      tests_failed++; $display("FAIL midrst got valid=%b key=%h want 0/%h", bus.out_valid, key_q, KEY_RST);
    end
    rst = 1'b0; key_load = 1'b0;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.out_valid) stale++;
    end
    tests_run++;
    if (stale != 0) begin
      tests_failed++; $display("FAIL midrst_stale got %0d want 0", stale);
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL midrst_data got %h want %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [31:0] o, e;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom % 3) != 0;
      roll_en       = $urandom % 2;
      key_load      = ($urandom % 16) == 0;
      key_in        = $urandom;
      tick();
      tests_run++;
      if (key_q !== model_key) begin
        tests_failed++; $display("FAIL rand_key cycle%0d got %h want %h", c, key_q, model_key);
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; key_load = 1'b0; roll_en = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL rand_data got %h want %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_identity();
    test_single_swaps();
    test_roll();
    test_backpressure();
    test_collision();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
